// File: rtl/cpu_move_if.sv
// Request/response bundle between the game FSM and the CPU move responder.
// Board vectors use bit i = cell i, row-major from the top-left corner.
interface cpu_move_if;
  logic       move_req;
  logic [8:0] board_p;
  logic [8:0] board_c;
  logic       busy;
  logic       move_valid;
  logic [3:0] move_idx;
  logic [8:0] move_onehot;
  logic       no_move;
  logic       cpu_wins;

  modport master (
    output move_req, board_p, board_c,
    input  busy, move_valid, move_idx, move_onehot, no_move, cpu_wins
  );

  modport slave (
    input  move_req, board_p, board_c,
    output busy, move_valid, move_idx, move_onehot, no_move, cpu_wins
  );
endinterface

// File: rtl/cpu_move_responder.sv
// CPU opponent: scans one winning line per cycle (win lines, then block lines),
// falls back to a fixed preference order, and answers with a one-cycle pulse.
module cpu_move_responder #(
  parameter int RESP_DELAY = 0
) (
  input  logic         clk,
  input  logic         rst,
  cpu_move_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WIN, S_BLOCK, S_FALLBACK, S_WAIT, S_RESP
  } state_t;

  localparam int CW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

  localparam logic [8:0] LINE_MASK [0:7] = '{
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };
  localparam logic [3:0] FB_ORDER [0:8] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  function automatic logic [3:0] lowest_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t         state_q, state_d;
  logic [2:0]     k_q, k_d;
  logic [8:0]     p_q, p_d, c_q, c_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [3:0]     choice_idx_q, choice_idx_d;
  logic           win_flag_q, win_flag_d;
  logic           none_flag_q, none_flag_d;
  logic           busy_q, busy_d;
  logic           move_valid_q, move_valid_d;
  logic           no_move_q, no_move_d;
  logic           cpu_wins_q, cpu_wins_d;
  logic [3:0]     move_idx_q, move_idx_d;
  logic [8:0]     move_onehot_q, move_onehot_d;

  logic [8:0]     empty;
  logic [7:0]     win_hit, blk_hit;
  logic [3:0]     gap_idx [0:7];
  logic           fb_found;
  logic [3:0]     fb_idx;
  logic           decided;
  logic           fire;

  // A cell claimed by both sides is simply occupied.
  assign empty = ~(p_q | c_q);

  for (genvar gi = 0; gi < 8; gi++) begin : g_line
    assign win_hit[gi] = ($countones(LINE_MASK[gi] & c_q) == 2) && ((LINE_MASK[gi] & empty) != '0);
    assign blk_hit[gi] = ($countones(LINE_MASK[gi] & p_q) == 2) && ((LINE_MASK[gi] & empty) != '0);
    assign gap_idx[gi] = lowest_idx(LINE_MASK[gi] & empty);
  end

  // Walk the preference list backwards so the earliest empty entry sticks.
  always_comb begin
    fb_found = 1'b0;
    fb_idx   = '0;
    for (int i = 8; i >= 0; i--) begin
      if (empty[FB_ORDER[i]]) begin
        fb_found = 1'b1;
        fb_idx   = FB_ORDER[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    p_d          = p_q;
    c_d          = c_q;
    wait_d       = wait_q;
    choice_idx_d = choice_idx_q;
    win_flag_d   = win_flag_q;
    none_flag_d  = none_flag_q;
    decided      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.move_req) begin
          p_d     = bus.board_p;
          c_d     = bus.board_c;
          k_d     = '0;
          state_d = S_WIN;
        end
      end
      S_WIN: begin
        if (win_hit[k_q]) begin
          choice_idx_d = gap_idx[k_q];
          win_flag_d   = 1'b1;
          none_flag_d  = 1'b0;
          decided      = 1'b1;
        end else if (k_q == 3'd7) begin
          k_d     = '0;
          state_d = S_BLOCK;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_BLOCK: begin
        if (blk_hit[k_q]) begin
          choice_idx_d = gap_idx[k_q];
          win_flag_d   = 1'b0;
          none_flag_d  = 1'b0;
          decided      = 1'b1;
        end else if (k_q == 3'd7) begin
          state_d = S_FALLBACK;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_FALLBACK: begin
        choice_idx_d = fb_idx;
        win_flag_d   = 1'b0;
        none_flag_d  = ~fb_found;
        decided      = 1'b1;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_RESP;
        else                     wait_d  = wait_q + 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (decided) begin
      wait_d  = '0;
      state_d = (RESP_DELAY > 0) ? S_WAIT : S_RESP;
    end

    // Outputs are registered: they are computed on the edge that enters RESP.
    fire          = (state_d == S_RESP);
    busy_d        = (state_d != S_IDLE);
    move_valid_d  = fire && !none_flag_d;
    no_move_d     = fire && none_flag_d;
    cpu_wins_d    = fire && !none_flag_d && win_flag_d;
    move_idx_d    = move_valid_d ? choice_idx_d : move_idx_q;
    move_onehot_d = move_valid_d ? (9'd1 << choice_idx_d) : 9'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      p_q           <= '0;
      c_q           <= '0;
      wait_q        <= '0;
      choice_idx_q  <= '0;
      win_flag_q    <= 1'b0;
      none_flag_q   <= 1'b0;
      busy_q        <= 1'b0;
      move_valid_q  <= 1'b0;
      no_move_q     <= 1'b0;
      cpu_wins_q    <= 1'b0;
      move_idx_q    <= '0;
      move_onehot_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      p_q           <= p_d;
      c_q           <= c_d;
      wait_q        <= wait_d;
      choice_idx_q  <= choice_idx_d;
      win_flag_q    <= win_flag_d;
      none_flag_q   <= none_flag_d;
      busy_q        <= busy_d;
      move_valid_q  <= move_valid_d;
      no_move_q     <= no_move_d;
      cpu_wins_q    <= cpu_wins_d;
      move_idx_q    <= move_idx_d;
      move_onehot_q <= move_onehot_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.move_valid  = move_valid_q;
  assign bus.no_move     = no_move_q;
  assign bus.cpu_wins    = cpu_wins_q;
  assign bus.move_idx    = move_idx_q;
  assign bus.move_onehot = move_onehot_q;

endmodule

// File: tb/tb_cpu_move_responder.sv
// Randomized bench for cpu_move_responder: two instances (RESP_DELAY 0 and 3)
// share stimulus; a line-table reference model predicts latency and choice.
module tb_cpu_move_responder;

  logic clk;
  logic rst;
  logic move_req;
  logic [8:0] board_p, board_c;
  logic sel3;

  cpu_move_if if0 ();
  cpu_move_if if3 ();

  assign if0.move_req = move_req;
  assign if0.board_p  = board_p;
  assign if0.board_c  = board_c;
  assign if3.move_req = move_req;
  assign if3.board_p  = board_p;
  assign if3.board_c  = board_c;

  cpu_move_responder #(.RESP_DELAY(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  cpu_move_responder #(.RESP_DELAY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic       mv, nm, cw, busy;
  logic [3:0] mi;
  logic [8:0] oh;

  always_comb begin
    if (sel3) begin
      mv = if3.move_valid; nm = if3.no_move; cw = if3.cpu_wins;
      busy = if3.busy; mi = if3.move_idx; oh = if3.move_onehot;
    end else begin
      mv = if0.move_valid; nm = if0.no_move; cw = if0.cpu_wins;
      busy = if0.busy; mi = if0.move_idx; oh = if0.move_onehot;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (txn %0d, t=%0t)", tag, got, exp, n_txn, $time);
    end
  endtask

  // Reference: cycle 0 is the request cycle; a decision in scan step s
  // (0..15 over win then block lines, 16 = fallback) lands in cycle s+1.
  function automatic void ref_move(input logic [8:0] p, input logic [8:0] c, input int dly,
                                   output int lat, output int idx, output bit win, output bit none);
    int lines [8][3];
    int fb [9];
    logic [8:0] e;
    lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    fb    = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
    e     = ~(p | c);
    lat = -1; idx = 0; win = 1'b0; none = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) begin
        int own;
        int gap;
        own = 0; gap = -1;
        for (int j = 0; j < 3; j++) begin
          if ((pass == 0) ? c[lines[k][j]] : p[lines[k][j]]) own++;
          else if (e[lines[k][j]]) gap = lines[k][j];
        end
        if (lat < 0 && own == 2 && gap >= 0) begin
          lat = 1 + 8 * pass + k + 1 + dly;
          idx = gap;
          win = (pass == 0);
        end
      end
    end
    if (lat < 0) begin
      lat  = 18 + dly;
      none = 1'b1;
      for (int i = 8; i >= 0; i--) begin
        if (e[fb[i]]) begin
          idx  = fb[i];
          none = 1'b0;
        end
      end
    end
  endfunction

  task automatic req(input logic [8:0] p, input logic [8:0] c, input int e_lat, input int e_idx,
                     input bit e_win, input bit e_none, input bit poke);
    int cyc;
    logic [3:0] idx_before;
    idx_before = mi;
    n_txn++;
    @(negedge clk);
    move_req = 1'b1; board_p = p; board_c = c;
    @(posedge clk); #1;
    cyc = 1;
    move_req = 1'b0;
    chk_eq("busy_c1", busy, 1);
    while (!(mv || nm) && cyc < 60) begin
      if (poke) begin
        move_req = 1'($urandom_range(0, 1));
        board_p  = 9'($urandom);
        board_c  = 9'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk_eq("latency", cyc, e_lat);
    chk_eq("move_valid", mv, !e_none);
    chk_eq("no_move", nm, e_none);
    chk_eq("cpu_wins", cw, e_win);
    chk_eq("busy_resp", busy, 1);
    chk_eq("move_idx", mi, e_none ? 32'(idx_before) : 32'(e_idx));
    chk_eq("onehot", oh, e_none ? 32'd0 : (32'd1 << e_idx));
    $display("txn %0d dly=%0d p=%03h c=%03h lat=%0d/%0d idx=%0d/%0d win=%0b none=%0b",
             n_txn, sel3 ? 3 : 0, p, c, cyc, e_lat, mi, e_idx, cw, nm);
    // A request during the response cycle must be ignored.
    if (poke) move_req = 1'b1;
    @(posedge clk); #1;
    move_req = 1'b0;
    chk_eq("busy_after", busy, 0);
    chk_eq("pulse_after", {mv, nm, cw}, 0);
    chk_eq("onehot_after", oh, 0);
    chk_eq("idx_hold", mi, e_none ? 32'(idx_before) : 32'(e_idx));
  endtask

  task automatic rand_board(output logic [8:0] p, output logic [8:0] c);
    p = '0; c = '0;
    for (int i = 0; i < 9; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 2)      p[i] = 1'b1;
      else if (r <= 5) c[i] = 1'b1;
      else if (r == 6) begin p[i] = 1'b1; c[i] = 1'b1; end
    end
  endtask

  task automatic rand_txns(input int n, input int dly);
    logic [8:0] p, c;
    int lat, idx;
    bit win, none;
    for (int t = 0; t < n; t++) begin
      rand_board(p, c);
      ref_move(p, c, dly, lat, idx, win, none);
      req(p, c, lat, idx, win, none, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    int seen;
    sel3 = 1'b0; rst = 1'b1; move_req = 1'b0; board_p = '0; board_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_pulses", {mv, nm, cw}, 0);
    chk_eq("rst_idx", mi, 0);
    chk_eq("rst_onehot", oh, 0);
    rst = 1'b0;

    req(9'h000, 9'h000, 18, 4, 1'b0, 1'b0, 1'b0);
    req(9'h010, 9'h003, 2, 2, 1'b1, 1'b0, 1'b0);
    req(9'h009, 9'h010, 13, 6, 1'b0, 1'b0, 1'b0);
    req(9'h003, 9'h0C0, 4, 8, 1'b1, 1'b0, 1'b0);
    req(9'h0AA, 9'h155, 18, 0, 1'b0, 1'b1, 1'b0);
    rand_txns(40, 0);

    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sel3 = 1'b1;
    req(9'h000, 9'h000, 21, 4, 1'b0, 1'b0, 1'b0);
    req(9'h010, 9'h003, 5, 2, 1'b1, 1'b0, 1'b1);
    rand_txns(10, 3);
    req(9'h000, 9'h0C0, 4 + 3, 8, 1'b1, 1'b0, 1'b0);

    // Abort a scan with reset in cycle 5.
    n_txn++;
    @(negedge clk);
    move_req = 1'b1; board_p = '0; board_c = '0;
    @(posedge clk); #1;
    move_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_idx", mi, 0);
    chk_eq("abort_onehot", oh, 0);
    chk_eq("abort_pulses", {mv, nm, cw}, 0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (mv || nm || cw || busy) seen++;
    end
    chk_eq("abort_quiet", seen, 0);
    $display("txn %0d dly=3 reset at cycle 5, activity cycles after=%0d", n_txn, seen);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
